instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Producer side of the decoder's instruction interface.
- Holds the fetch PC and issues single-outstanding reads to instruction memory.
- Buffers returned words in a small FIFO and presents Instr/PC to the control unit and datapath with a valid/ready handshake.
- Consumes PCSrc from the decoder to redirect, flush or halt fetch.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- DEPTH, 2, instruction FIFO entries (power of 2, ≥2).

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  read request to instruction memory
- imem_addr  out  32  word-aligned read address (= fetch_pc)
- imem_gnt  in  1  memory accepts request this cycle
- imem_rvalid  in  1  read data valid (≥1 cycle after grant)
- imem_rdata  in  32  returned instruction word
- Instr  out  32  FIFO head instruction; 32'h0000_0013 (NOP) when empty
- InstrPC  out  32  PC of head instruction; 0 when empty
- PCPlus4  out  32  InstrPC + 4
- Instr_valid  out  1  head entry present and state RUN
- Instr_ready  in  1  decoder consumes head this cycle
- PCSrc  in  2  next-PC select, sampled only on handshake: 00 sequential, 01 PCTarget, 10 ALUResult, 11 halt
- PCTarget  in  32  PC-relative branch/jal target
- ALUResult  in  32  jalr target; bit 0 forced to 0

Behaviour:
- Reset (async, rst=1): fetch_pc=RESET_PC, count=0, outstanding=0, drop=0, state=RUN; Instr_valid=0, imem_req=0 (gated by rst), Instr=NOP.
- States: RUN, HALT. RUN→HALT on handshake with PCSrc=11. HALT exits only via rst.
- Handshake fire = Instr_valid & Instr_ready; pops head.
- redirect = fire & PCSrc∈{01,10}; target = PCTarget or {ALUResult[31:1],1'b0}.
- imem_req = !rst & RUN & !outstanding & (count+outstanding < DEPTH); not gated by redirect.
- On imem_req & imem_gnt: outstanding←1, fetch_pc←fetch_pc+4 (wraps mod 2^32).
- On imem_rvalid: outstanding←0. If drop, or redirect/halt this cycle: discard the word and clear drop. Otherwise push {imem_rdata, addr of that request}.
  - Each FIFO entry stores its own PC. A per-request PC register captures imem_addr at grant.
- Redirect:
  - FIFO flushed (count←0; the popped entry is already consumed).
  - fetch_pc←target; this overrides +4 if a grant occurs the same cycle.
  - If a request is outstanding, or granted this cycle, and not returning this cycle: drop←1.
- Halt (fire & PCSrc=11): flush FIFO, drop←1 if in flight. No further requests. Instr_valid=0 thereafter.
- Sequential pop (PCSrc=00) with simultaneous push: count unchanged, order preserved.
- FIFO can never overflow; the request condition reserves a slot. Push with count=DEPTH is an assertion failure.
- Latency: first Instr_valid no earlier than 2 cycles after rst deassert with a zero-wait memory (req/gnt cycle 0, rvalid cycle 1, valid cycle 2).
- Instr/InstrPC/PCPlus4 are combinational from the FIFO head. Instr_valid does not depend on Instr_ready.
- Reset mid-operation: in-flight response is not tracked after reset. The memory is reset by the same rst.

Test Plan:
- Reset then zero-wait memory returning addr-tagged words, Instr_ready=1, PCSrc=00 → Instr_valid first high cycle 2; InstrPC sequence 0x0,0x4,0x8,0xC with matching Instr; imem_addr increments by 4.
- Instr_ready=0 for 6 cycles → exactly DEPTH=2 entries fill, imem_req drops to 0; raise ready → entries 0x0,0x4 drain in order with no loss or duplication.
- Handshake at InstrPC=0x8 with PCSrc=01, PCTarget=0x100 while a request for 0xC is outstanding → 0xC response discarded, FIFO flushed; next valid InstrPC=0x100, then 0x104.
- PCSrc=10, ALUResult=0x203, coinciding with imem_rvalid → that response discarded; next fetch address 0x202 (bit0 cleared), InstrPC=0x202.
- PCSrc=11 on handshake → Instr_valid stays 0, imem_req stays 0 for 20 cycles; assert rst for 1 cycle → fetch restarts at RESET_PC=0x0.
- Memory with random 0-3 cycle grant and response delays, 200 instructions, random ready → InstrPC stream strictly +4 between redirects; never more than 1 outstanding request; FIFO never overflows.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: single-outstanding instruction-memory reader feeding a small
// PC-tagged FIFO that presents Instr/InstrPC to the decoder over a valid/ready handshake.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr,
  output logic [31:0] InstrPC,
  output logic [31:0] PCPlus4,
  output logic        Instr_valid,
  input  logic        Instr_ready,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] PCTarget,
  input  logic [31:0] ALUResult
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t        state_q;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_pc_q;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic          outstanding_q, outstanding_d;
  logic          drop_q, drop_d;

  logic [31:0] instr_mem [DEPTH];
  logic [31:0] pc_mem    [DEPTH];

  logic          run, empty, fire, redirect, halt, flush, grant, push;
  logic [31:0]   target;
  logic [CW-1:0] in_flight;

  assign run         = (state_q == S_RUN);
  assign empty       = (count_q == '0);
  assign Instr_valid = run & ~empty;
  assign fire        = Instr_valid & Instr_ready;
  assign redirect    = fire & ((PCSrc == 2'b01) | (PCSrc == 2'b10));
  assign halt        = fire & (PCSrc == 2'b11);
  assign flush       = redirect | halt;
  assign target      = (PCSrc == 2'b01) ? PCTarget : (ALUResult & ~32'h1);

  // A request is only issued when its response is guaranteed a free FIFO slot.
  assign in_flight = {{(CW-1){1'b0}}, outstanding_q};
  assign imem_req  = ~rst & run & ~outstanding_q & ((count_q + in_flight) < CW'(DEPTH));
  assign imem_addr = fetch_pc_q;
  assign grant     = imem_req & imem_gnt;
  assign push      = imem_rvalid & ~drop_q & ~flush;

  assign Instr   = empty ? NOP   : instr_mem[rd_ptr_q];
  assign InstrPC = empty ? 32'h0 : pc_mem[rd_ptr_q];
  assign PCPlus4 = InstrPC + 32'd4;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    rd_ptr_d      = rd_ptr_q + AW'(fire);
    wr_ptr_d      = wr_ptr_q + AW'(push);
    count_d       = count_q + CW'(push) - CW'(fire);

    if (grant)       fetch_pc_d = fetch_pc_q + 32'd4;
    if (redirect)    fetch_pc_d = target;
    if (imem_rvalid) outstanding_d = 1'b0;
    if (grant)       outstanding_d = 1'b1;
    if (imem_rvalid) drop_d = 1'b0;
    // A response still in flight after a flush belongs to the old stream.
    if (flush && (outstanding_q || grant) && !imem_rvalid) drop_d = 1'b1;

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_RUN;
      fetch_pc_q    <= RESET_PC;
      req_pc_q      <= RESET_PC;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
    end else begin
      if (halt) state_q <= S_HALT;
      if (grant) req_pc_q <= fetch_pc_q;
      fetch_pc_q    <= fetch_pc_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= imem_rdata;
      pc_mem[wr_ptr_q]    <= req_pc_q;
    end
  end

  no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && (count_q == CW'(DEPTH))));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: behavioural instruction memory with
// optional random delays, and a PC scoreboard filled at each handshake.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] Instr, InstrPC, PCPlus4;
  logic        Instr_valid;
  logic        Instr_ready = 1'b0;
  logic [1:0]  PCSrc = 2'b00;
  logic [31:0] PCTarget = 32'h0;
  logic [31:0] ALUResult = 32'h0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .Instr(Instr), .InstrPC(InstrPC), .PCPlus4(PCPlus4),
    .Instr_valid(Instr_valid), .Instr_ready(Instr_ready),
    .PCSrc(PCSrc), .PCTarget(PCTarget), .ALUResult(ALUResult)
  );

  int checks = 0;
  int failures = 0;
  int nhs = 0;
  bit halted = 0;
  logic [31:0] exp_q[$];

  bit          mem_rand = 0;
  bit          pend = 0;
  logic [31:0] pend_addr = 32'h0;
  int          rsp_wait = 0;
  int          gnt_wait = 0;
  int          ngrants = 0;
  logic [31:0] gaddr[$];

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h5A00_0013;
  endfunction

  // Instruction memory: outputs set on the falling edge, bookkeeping on the rising edge.
  always @(negedge clk) begin
    if (rst) begin
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end else begin
      imem_rvalid = pend && (rsp_wait == 0);
      imem_rdata  = imem_rvalid ? word_of(pend_addr) : 32'hDEAD_BEEF;
      imem_gnt    = imem_req && (gnt_wait == 0);
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      pend     = 0;
      rsp_wait = 0;
      gnt_wait = 0;
    end else begin
      if (imem_rvalid) pend = 0;
      else if (pend && rsp_wait > 0) rsp_wait--;
      if (imem_req && imem_gnt) begin
        pend      = 1;
        pend_addr = imem_addr;
        rsp_wait  = mem_rand ? int'($urandom_range(0, 3)) : 0;
        gnt_wait  = mem_rand ? int'($urandom_range(0, 3)) : 0;
        gaddr.push_back(imem_addr);
        ngrants++;
      end else if (imem_req && gnt_wait > 0) begin
        gnt_wait--;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
    if (!rst && imem_req && imem_gnt) begin
      checks++;
      if (pend && !imem_rvalid) begin
        failures++;
        $display("FAIL single_outstanding actual=grant_with_pending addr=%h expected=no_grant", imem_addr);
      end
    end
  endtask

  task automatic sb_handshake(input logic [1:0] src, input logic [31:0] tgt, input logic [31:0] alu);
    logic [31:0] e;
    nhs++;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_empty actual InstrPC=%h expected=no_valid", InstrPC);
    end else begin
      e = exp_q.pop_front();
      chk("InstrPC", InstrPC, e);
      chk("Instr", Instr, word_of(e));
      chk("PCPlus4", PCPlus4, e + 32'd4);
      $display("hs %0d pc=%h instr=%h pcsrc=%b", nhs, InstrPC, Instr, src);
      case (src)
        2'b00: exp_q.push_back(e + 32'd4);
        2'b01: exp_q.push_back(tgt);
        2'b10: exp_q.push_back(alu & ~32'h1);
        default: halted = 1;
      endcase
    end
  endtask

  task automatic drive_cycle(input logic rdy, input logic [1:0] src, input logic [31:0] tgt, input logic [31:0] alu);
    tick();
    Instr_ready = rdy;
    PCSrc       = src;
    PCTarget    = tgt;
    ALUResult   = alu;
    if (Instr_valid && rdy) sb_handshake(src, tgt, alu);
  endtask

  task automatic next_hs(input logic [1:0] src, input logic [31:0] tgt, input logic [31:0] alu,
                         output logic [31:0] pc);
    bit done = 0;
    pc = 32'hFFFF_FFFF;
    for (int i = 0; i < 60 && !done; i++) begin
      tick();
      Instr_ready = 1'b1;
      PCSrc       = src;
      PCTarget    = tgt;
      ALUResult   = alu;
      if (Instr_valid) begin
        pc = InstrPC;
        sb_handshake(src, tgt, alu);
        done = 1;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL hs_timeout actual=no_valid expected=handshake_within_60");
    end
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    Instr_ready = 1'b0;
    PCSrc = 2'b00;
    #1;
    chk("rst_valid", 32'(Instr_valid), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_instr", Instr, NOP);
    chk("rst_pc", InstrPC, 32'h0);
    chk("rst_addr", imem_addr, RESET_PC);
    @(posedge clk);
    #2;
    rst = 1'b0;
    exp_q.delete();
    exp_q.push_back(RESET_PC);
    halted = 0;
  endtask

  typedef struct {
    logic [1:0]  src;
    logic [31:0] tgt;
    logic [31:0] alu;
    bit          hold;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int base, first_k, k, hs0;
    logic [31:0] pc;

    tbl[0] = '{2'b00, 32'h0,   32'h0,   1'b0, 32'h0000_0000};
    tbl[1] = '{2'b00, 32'h0,   32'h0,   1'b0, 32'h0000_0004};
    tbl[2] = '{2'b01, 32'h100, 32'h0,   1'b0, 32'h0000_0008};
    tbl[3] = '{2'b10, 32'h0,   32'h203, 1'b1, 32'h0000_0100};
    tbl[4] = '{2'b00, 32'h0,   32'h0,   1'b0, 32'h0000_0202};
    tbl[5] = '{2'b00, 32'h0,   32'h0,   1'b0, 32'h0000_0206};

    // Zero-wait memory, always ready: first-valid latency and sequential stream.
    do_reset();
    base = ngrants;
    first_k = -1;
    hs0 = nhs;
    k = 0;
    while (nhs - hs0 < 4 && k < 40) begin
      tick();
      Instr_ready = 1'b1;
      PCSrc = 2'b00;
      if (Instr_valid) begin
        if (first_k < 0) first_k = k;
        sb_handshake(2'b00, 32'h0, 32'h0);
      end
      k++;
    end
    chk("first_valid_cycle", 32'(first_k), 32'd2);
    chk("seq_hs_count", 32'(nhs - hs0), 32'd4);
    if (ngrants - base < 4) begin
      checks++;
      failures++;
      $display("FAIL seq_grants actual=%0d expected>=4", ngrants - base);
    end else begin
      for (int i = 0; i < 4; i++) chk("seq_imem_addr", gaddr[base + i], RESET_PC + 32'(4 * i));
    end

    // Back-pressure: the FIFO fills to DEPTH and requests stop.
    do_reset();
    base = ngrants;
    for (int i = 0; i < 6; i++) drive_cycle(1'b0, 2'b00, 32'h0, 32'h0);
    chk("full_req", 32'(imem_req), 32'd0);
    chk("full_grants", 32'(ngrants - base), 32'(DEPTH));
    chk("full_valid", 32'(Instr_valid), 32'd1);
    next_hs(2'b00, 32'h0, 32'h0, pc);
    chk("drain0", pc, 32'h0);
    next_hs(2'b00, 32'h0, 32'h0, pc);
    chk("drain1", pc, 32'h4);

    // Redirect table: PCTarget, ALUResult coinciding with a response.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].hold) begin
        for (int j = 0; j < 40; j++) begin
          tick();
          Instr_ready = 1'b0;
          if (Instr_valid) break;
        end
      end
      next_hs(tbl[i].src, tbl[i].tgt, tbl[i].alu, pc);
      chk("tbl_pc", pc, tbl[i].exp_pc);
    end

    // Halt, then recover only through reset.
    next_hs(2'b11, 32'h0, 32'h0, pc);
    chk("halt_pc", pc, 32'h20A);
    for (int i = 0; i < 20; i++) begin
      drive_cycle(1'b1, 2'b00, 32'h0, 32'h0);
      chk("halt_valid", 32'(Instr_valid), 32'd0);
      chk("halt_req", 32'(imem_req), 32'd0);
    end
    do_reset();
    base = ngrants;
    next_hs(2'b00, 32'h0, 32'h0, pc);
    chk("restart_pc", pc, RESET_PC);
    if (ngrants - base < 1) begin
      checks++;
      failures++;
      $display("FAIL restart_grant actual=0 expected>=1");
    end else begin
      chk("restart_addr", gaddr[base], RESET_PC);
    end

    // Random memory delays and ready, occasional redirects.
    do_reset();
    mem_rand = 1;
    hs0 = nhs;
    for (int c = 0; c < 8000 && (nhs - hs0) < 200; c++) begin
      int r;
      logic [1:0] src;
      r = int'($urandom_range(0, 9));
      src = (r == 0) ? 2'b01 : (r == 1) ? 2'b10 : 2'b00;
      drive_cycle(1'($urandom_range(0, 1)), src,
                  32'($urandom_range(0, 1023)) << 2, 32'($urandom_range(0, 4095)));
    end
    chk("rand_hs_count", 32'(nhs - hs0), 32'd200);
    chk("rand_not_halted", 32'(halted), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
